// File: rtl/ofe_pkg.sv
// ofe_pkg
//   Shared definitions for the output delay bank: GSR mode strings,
//   the fill-counter width helper and the tap-select clamp.
//   No ports; imported by ofe_delay_lane and ofe_delay_bank.
package ofe_pkg;

  localparam string GSR_ENABLED  = "ENABLED";
  localparam string GSR_DISABLED = "DISABLED";

  // Counter must be able to hold the value DEPTH itself (saturation point).
  function automatic int cntw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Out-of-range tap selects collapse onto the deepest tap, so Q is never
  // sourced from a stage that does not exist.
  function automatic int sel_clamp(input int field, input int depth);
    return (field > depth - 1) ? depth - 1 : field;
  endfunction

endpackage

// File: rtl/ofe_delay_lane.sv
// ofe_delay_lane
//   One lane of the output delay bank: a (DEPTH-1)-stage shift line, a tap
//   mux and the registered output bit. Latency from d to q is sel+1 enabled
//   edges (sel=0 registers d directly).
//   Ports:
//     clk  in   edge clock
//     rst  in   synchronous reset (already combined), overrides en
//     en   in   clock enable for the line and q
//     d    in   lane data
//     sel  in   clamped tap select, 0..DEPTH-1
//     q    out  registered lane output
module ofe_delay_lane #(
  parameter int   DEPTH     = 4,
  parameter int   SELW      = 2,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            d,
  input  logic [SELW-1:0] sel,
  output logic            q
);

  logic [DEPTH-2:0] stage_reg;
  logic             tap;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {(DEPTH-1){RESET_BIT}};
      q         <= RESET_BIT;
    end else if (en) begin
      for (int k = DEPTH - 2; k > 0; k--) begin
        stage_reg[k] <= stage_reg[k-1];
      end
      stage_reg[0] <= d;
      q            <= tap;
    end
  end

  // stage_reg[k] holds d from k+1 enabled edges ago, so tap sel picks
  // stage_reg[sel-1]; a loop keeps the index in range for any DEPTH.
  always_comb begin
    tap = d;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (int'(sel) == k + 1) tap = stage_reg[k];
    end
  end

endmodule

// File: rtl/ofe_delay_bank.sv
// ofe_delay_bank
//   WIDTH-lane output skew-alignment bank. Each lane is a programmable
//   delay line (1..DEPTH enabled edges); a shared fill counter drives a
//   per-lane valid flag telling downstream logic when the lane output
//   carries data sampled since the last reset.
//   Ports:
//     ECLK    in   edge clock, all state updates on the rising edge
//     CD      in   synchronous active-high clear, highest priority
//     SP      in   clock enable for delay lines, Q, fill counter and QV
//     GSRNET  in   global set/reset net, active low (used when GSR="ENABLED")
//     PURNET  in   power-up reset net, active low
//     D       in   [WIDTH] lane data
//     DSEL    in   [WIDTH*SELW] tap selects, lane i at [i*SELW +: SELW]
//     Q       out  [WIDTH] registered lane data
//     QV      out  [WIDTH] per-lane valid
module ofe_delay_bank
  import ofe_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 4,
  parameter int               SELW      = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter string            GSR       = GSR_ENABLED
) (
  input  logic                  ECLK,
  input  logic                  CD,
  input  logic                  SP,
  input  logic                  GSRNET,
  input  logic                  PURNET,
  input  logic [WIDTH-1:0]      D,
  input  logic [WIDTH*SELW-1:0] DSEL,
  output logic [WIDTH-1:0]      Q,
  output logic [WIDTH-1:0]      QV
);

  localparam int CW     = cntw(DEPTH);
  localparam bit GSR_ON = (GSR == GSR_ENABLED);

  logic            rst;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic [SELW-1:0] sel_w [WIDTH];

  // Combined reset is only ever consumed inside clocked processes.
  assign rst = CD | (GSR_ON ? ~GSRNET : 1'b0) | ~PURNET;

  // Fill counter: counts enabled edges since reset, sticks at DEPTH.
  always_comb begin
    count_next = count_reg;
    if (rst) begin
      count_next = '0;
    end else if (SP && (count_reg != CW'(DEPTH))) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge ECLK) begin
    count_reg <= count_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign sel_w[gi] = SELW'(sel_clamp(int'(DSEL[gi*SELW +: SELW]), DEPTH));

      ofe_delay_lane #(
        .DEPTH     (DEPTH),
        .SELW      (SELW),
        .RESET_BIT (RESET_VAL[gi])
      ) u_lane (
        .clk (ECLK),
        .rst (rst),
        .en  (SP),
        .d   (D[gi]),
        .sel (sel_w[gi]),
        .q   (Q[gi])
      );
    end
  endgenerate

  // A lane is valid once more enabled edges have elapsed than its tap depth,
  // i.e. on the same edge its Q first carries a post-reset sample. Raising
  // the select past the fill level drops QV until the line refills.
  always_ff @(posedge ECLK) begin
    if (rst) begin
      QV <= '0;
    end else if (SP) begin
      for (int i = 0; i < WIDTH; i++) begin
        QV[i] <= (int'(count_next) > int'(sel_w[i]));
      end
    end
  end

endmodule

// File: tb/tb_ofe_delay_bank.sv
// tb_ofe_delay_bank
//   Two bank instances share stimulus: A (DEPTH=4, RESET_VAL=1010, GSR on)
//   and B (DEPTH=5, SELW=3, RESET_VAL=0110, GSR off). The driver pushes the
//   expected Q/QV of every edge into a queue per instance; a monitor pops
//   and compares after each rising edge.
module tb_ofe_delay_bank;

  localparam logic [3:0] RV_A = 4'b1010;
  localparam logic [3:0] RV_B = 4'b0110;

  logic        ECLK = 1'b0;
  logic        CD, SP, GSRNET, PURNET;
  logic [3:0]  D;
  logic [7:0]  DSEL_A;
  logic [11:0] DSEL_B;
  logic [3:0]  q_a, qv_a, q_b, qv_b;

  always #5 ECLK = ~ECLK;

  ofe_delay_bank #(.WIDTH(4), .DEPTH(4), .RESET_VAL(RV_A), .GSR("ENABLED")) dut_a (
    .ECLK(ECLK), .CD(CD), .SP(SP), .GSRNET(GSRNET), .PURNET(PURNET),
    .D(D), .DSEL(DSEL_A), .Q(q_a), .QV(qv_a)
  );

  ofe_delay_bank #(.WIDTH(4), .DEPTH(5), .RESET_VAL(RV_B), .GSR("DISABLED")) dut_b (
    .ECLK(ECLK), .CD(CD), .SP(SP), .GSRNET(GSRNET), .PURNET(PURNET),
    .D(D), .DSEL(DSEL_B), .Q(q_b), .QV(qv_b)
  );

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] qv;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: per instance, the number of enabled edges since reset
  // and a log of D indexed by that edge number. Q on edge n with tap s is the
  // D logged on edge n-s, or the reset value if that edge predates reset.
  int         n_edges [2];
  logic [3:0] dlog    [2][64];
  exp_t       last    [2];

  task automatic model_edge(input int id, input bit rst, input bit sp, input logic [3:0] d,
                            input logic [11:0] dsel, input int selw, input int depth,
                            input logic [3:0] rv, output exp_t e);
    int s;
    e = last[id];
    if (rst) begin
      n_edges[id] = 0;
      e.q  = rv;
      e.qv = 4'b0000;
    end else if (sp) begin
      n_edges[id] = n_edges[id] + 1;
      dlog[id][n_edges[id] % 64] = d;
      for (int i = 0; i < 4; i++) begin
        s = int'((dsel >> (i * selw)) & ((12'd1 << selw) - 12'd1));
        if (s > depth - 1) s = depth - 1;
        if (n_edges[id] > s) begin
          e.q[i]  = dlog[id][(n_edges[id] - s) % 64][i];
          e.qv[i] = 1'b1;
        end else begin
          e.q[i]  = rv[i];
          e.qv[i] = 1'b0;
        end
      end
    end
    last[id] = e;
  endtask

  task automatic step(input logic cd, input logic sp, input logic gsrn, input logic purn,
                      input logic [3:0] d, input logic [7:0] da, input logic [11:0] db);
    exp_t ea, eb;
    @(negedge ECLK);
    CD = cd; SP = sp; GSRNET = gsrn; PURNET = purn; D = d; DSEL_A = da; DSEL_B = db;
    model_edge(0, cd | ~gsrn | ~purn, sp, d, {4'b0, da}, 2, 4, RV_A, ea);
    model_edge(1, cd | ~purn,         sp, d, db,         3, 5, RV_B, eb);
    exp_a.push_back(ea);
    exp_b.push_back(eb);
  endtask

  function automatic void check(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor
  initial begin
    exp_t e;
    int   edge_no = 0;
    forever begin
      @(posedge ECLK);
      #1;
      if (exp_a.size() > 0 && exp_b.size() > 0) begin
        edge_no++;
        e = exp_a.pop_front();
        check("a_q", q_a, e.q);
        check("a_qv", qv_a, e.qv);
        e = exp_b.pop_front();
        check("b_q", q_b, e.q);
        check("b_qv", qv_b, e.qv);
        $display("edge %0d cd=%b sp=%b d=%h | a q=%b qv=%b | b q=%b qv=%b",
                 edge_no, CD, SP, D, q_a, qv_a, q_b, qv_b);
      end
    end
  end

  // Driver
  initial begin
    logic [7:0]  da;
    logic [11:0] db;
    CD = 1'b1; SP = 1'b0; GSRNET = 1'b1; PURNET = 1'b1; D = '0; DSEL_A = '0; DSEL_B = '0;

    // Reset holds even with SP high and D toggling.
    repeat (3) step(1, 1, 1, 1, 4'($urandom), 8'h00, 12'h000);

    // Staggered taps: A lanes {3,2,1,0}; B lanes {7(clamped to 4),3,1,0}.
    da = {2'd3, 2'd2, 2'd1, 2'd0};
    db = {3'd7, 3'd3, 3'd1, 3'd0};
    for (int k = 1; k <= 10; k++) step(0, 1, 1, 1, 4'(k), da, db);
    // Freeze for 3 cycles, then resume the sequence.
    repeat (3) step(0, 0, 1, 1, 4'($urandom), da, db);
    for (int k = 11; k <= 16; k++) step(0, 1, 1, 1, 4'(k), da, db);

    // Lane1 select 0 -> 3 after two enabled edges; then run to saturation.
    step(1, 1, 1, 1, 4'h0, 8'h00, 12'h000);
    repeat (2) step(0, 1, 1, 1, 4'($urandom), 8'h00, 12'h000);
    repeat (20) step(0, 1, 1, 1, 4'($urandom), 8'b00_00_11_00, 12'b000_000_100_000);

    // One-cycle CD pulse mid-stream, then refill.
    step(1, 1, 1, 1, 4'($urandom), da, db);
    repeat (6) step(0, 1, 1, 1, 4'($urandom), da, db);

    // GSRNET low: resets A only (B has GSR disabled).
    repeat (3) step(0, 1, 0, 1, 4'($urandom), da, db);
    repeat (4) step(0, 1, 1, 1, 4'($urandom), da, db);

    // PURNET low: resets both.
    step(0, 1, 1, 0, 4'($urandom), da, db);
    repeat (5) step(0, 1, 1, 1, 4'($urandom), da, db);

    // Randomized traffic.
    for (int k = 0; k < 250; k++) begin
      step(($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 50) != 0,
           ($urandom % 60) != 0, 4'($urandom), 8'($urandom), 12'($urandom));
    end

    repeat (3) @(posedge ECLK);
    #2;
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d/%0d required=0/0", exp_a.size(), exp_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
